// File: rtl/mac_sequencer.sv
// Sequential unsigned shift-and-add multiplier feeding a sticky-overflow accumulator.
// The start/busy/done handshake is driven from the registered FSM state only.
module mac_sequencer #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MULT  = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [CW-1:0]      cnt_reg;
  logic [ACC_WIDTH-1:0] acc_reg;
  logic               overflow_reg;

  // One extra bit captures the carry out of the accumulator.
  logic [ACC_WIDTH:0] acc_sum;
  assign acc_sum = {1'b0, acc_reg} + (ACC_WIDTH + 1)'(prod_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      prod_reg     <= '0;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clear) begin
            acc_reg      <= '0;
            overflow_reg <= 1'b0;
          end
          if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            state_reg  <= ST_MULT;
          end
        end
        ST_MULT: begin
          if (mplier_reg[0])
            prod_reg <= prod_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          // Always runs the full WIDTH steps so latency is data-independent.
          if (cnt_reg == CW'(WIDTH - 1))
            state_reg <= ST_ACCUM;
        end
        ST_ACCUM: begin
          acc_reg      <= acc_sum[ACC_WIDTH-1:0];
          overflow_reg <= overflow_reg | acc_sum[ACC_WIDTH];
          state_reg    <= ST_DONE;
        end
        default: begin
          if (clear) begin
            acc_reg      <= '0;
            overflow_reg <= 1'b0;
          end
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_reg == ST_MULT) || (state_reg == ST_ACCUM);
  assign done     = (state_reg == ST_DONE);
  assign acc      = acc_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: default instance (ACC_WIDTH=20) and a narrow one (ACC_WIDTH=16).
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, clear = 1'b0;
  logic        start2 = 1'b0, clear2 = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        busy, done, overflow;
  logic [19:0] acc;
  logic        busy2, done2, overflow2;
  logic [15:0] acc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.WIDTH(8), .ACC_WIDTH(20)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .a(a), .b(b),
    .busy(busy), .done(done), .acc(acc), .overflow(overflow)
  );

  mac_sequencer #(.WIDTH(8), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start2), .clear(clear2), .a(a), .b(b),
    .busy(busy2), .done(done2), .acc(acc2), .overflow(overflow2)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Issues one operation; lat = edges after the accepting edge until done is seen,
  // bcnt = sampled cycles with busy high.
  task automatic do_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                       input bit clr, output int lat, output int bcnt);
    a = av; b = bv;
    if (sel) begin start2 = 1'b1; clear2 = clr; end
    else     begin start  = 1'b1; clear  = clr; end
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0; clear = 1'b0; clear2 = 1'b0;
    a = 8'hA5; b = 8'h5A;
    lat = 0; bcnt = 0;
    while (!(sel ? done2 : done) && lat < 30) begin
      if (sel ? busy2 : busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 30) check_eq("op_timeout", lat, 9);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear(input bit sel);
    if (sel) clear2 = 1'b1; else clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; clear2 = 1'b0;
  endtask

  int lat, bcnt, ndone;

  initial begin
    #12;
    check_eq("reset_acc", acc, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_ovf", overflow, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // 1: 3*5
    do_op(0, 8'd3, 8'd5, 0, lat, bcnt);
    check_eq("t1_latency", lat, 9);
    check_eq("t1_busy_cycles", bcnt, 9);
    check_eq("t1_acc", acc, 15);
    check_eq("t1_ovf", overflow, 0);
    check_eq("t1_idle_done", done, 0);

    // 2: 255*255 twice, accumulate
    pulse_clear(0);
    check_eq("t2_cleared", acc, 0);
    do_op(0, 8'd255, 8'd255, 0, lat, bcnt);
    check_eq("t2_acc1", acc, 65025);
    do_op(0, 8'd255, 8'd255, 0, lat, bcnt);
    check_eq("t2_acc2", acc, 130050);
    check_eq("t2_ovf", overflow, 0);

    // 3: narrow accumulator wraps and sets sticky overflow
    do_op(1, 8'd255, 8'd255, 0, lat, bcnt);
    check_eq("t3_acc1", acc2, 65025);
    check_eq("t3_ovf1", overflow2, 0);
    do_op(1, 8'd255, 8'd255, 0, lat, bcnt);
    check_eq("t3_acc2", acc2, 64514);
    check_eq("t3_ovf2", overflow2, 1);
    pulse_clear(1);
    check_eq("t3_clr_acc", acc2, 0);
    check_eq("t3_clr_ovf", overflow2, 0);

    // 4: start and clear during an op are ignored
    pulse_clear(0);
    a = 8'd6; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;               // E0
    start = 1'b0;
    @(posedge clk); #1;               // E1
    @(posedge clk); #1;               // E2
    a = 8'd7; b = 8'd7; start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;               // E3
    start = 1'b0; clear = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check_eq("t4_done_count", ndone, 1);
    check_eq("t4_acc", acc, 30);
    check_eq("t4_busy_end", busy, 0);

    // 5: reset mid-operation aborts with no accumulate
    a = 8'd200; b = 8'd200; start = 1'b1;
    @(posedge clk); #1;               // E0
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(posedge clk); #1;               // E4
    reset = 1'b0;
    #1;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_acc", acc, 0);
    check_eq("t5_done", done, 0);
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_busy_after", busy, 0);
    do_op(0, 8'd2, 8'd3, 0, lat, bcnt);
    check_eq("t5_acc_after", acc, 6);

    // 6: clear+start together, then zero operand
    do_op(0, 8'd10, 8'd10, 1, lat, bcnt);
    check_eq("t6_acc100", acc, 100);
    do_op(0, 8'd4, 8'd4, 1, lat, bcnt);
    check_eq("t6_acc16", acc, 16);
    do_op(0, 8'd0, 8'd9, 0, lat, bcnt);
    check_eq("t6_zero_latency", lat, 9);
    check_eq("t6_zero_acc", acc, 16);
    check_eq("t6_ovf", overflow, 0);

    // clear in DONE takes effect on the edge leaving DONE
    do_op(0, 8'd1, 8'd1, 0, lat, bcnt);
    check_eq("t7_acc17", acc, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
